// File: rtl/sync_filter_multi.sv
// Multi-channel synchroniser for asynchronous inputs entering the CLK domain.
// Each channel has a flip-flop chain, a consecutive-sample glitch filter and registered edge pulses.
module sync_filter_multi #(
    parameter int              WIDTH    = 4,
    parameter int              STAGES   = 2,
    parameter int              FILT_LEN = 3,
    parameter logic [WIDTH-1:0] INIT    = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             aclr_i,
    input  logic [WIDTH-1:0] async_in,
    input  logic             filt_bypass,
    output logic [WIDTH-1:0] sync_raw,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int              CW      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(FILT_LEN - 1);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_filter_multi: STAGES must be at least 2");
        end
        if (FILT_LEN < 1 || FILT_LEN > 256) begin : g_bad_filt
            $error("sync_filter_multi: FILT_LEN must be in 1..256");
        end
    endgenerate

    logic [WIDTH-1:0] stage [STAGES];
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic [WIDTH-1:0] out_nxt;

    // Plain flop chain: only stage[0] can go metastable, nothing sits between stages.
    always_ff @(posedge CLK or posedge aclr_i) begin
        if (aclr_i) begin
            for (int n = 0; n < STAGES; n++) begin
                stage[n] <= INIT;
            end
        end else begin
            stage[0] <= async_in;
            for (int n = 1; n < STAGES; n++) begin
                stage[n] <= stage[n-1];
            end
        end
    end

    assign sync_raw = stage[STAGES-1];

    always_comb begin
        out_nxt = sync_out;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (filt_bypass) begin
                out_nxt[i] = sync_raw[i];
            end else if (sync_raw[i] != sync_out[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    out_nxt[i] = sync_raw[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Edge pulses are registered from the next-state value so they align with the sync_out update.
    always_ff @(posedge CLK or posedge aclr_i) begin
        if (aclr_i) begin
            sync_out <= INIT;
            rise     <= '0;
            fall     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_out <= out_nxt;
            rise     <= out_nxt & ~sync_out;
            fall     <= ~out_nxt & sync_out;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_sync_filter_multi.sv
// Bench for sync_filter_multi: three builds driven in parallel, checked by a scoreboard
// against a delay-line / mismatch-run reference model, plus directed latency checks.
module tb_sync_filter_multi;

    localparam int ND = 3;

    logic       CLK = 1'b0;
    logic       aclr_i;
    logic [3:0] async_in;
    logic       filt_bypass;
    logic [3:0] raw_o  [ND];
    logic [3:0] out_o  [ND];
    logic [3:0] rise_o [ND];
    logic [3:0] fall_o [ND];

    always #5 CLK = ~CLK;

    sync_filter_multi u_a (
        .CLK(CLK), .aclr_i(aclr_i), .async_in(async_in), .filt_bypass(filt_bypass),
        .sync_raw(raw_o[0]), .sync_out(out_o[0]), .rise(rise_o[0]), .fall(fall_o[0])
    );

    sync_filter_multi #(.WIDTH(4), .STAGES(2), .FILT_LEN(3), .INIT(4'b0101)) u_b (
        .CLK(CLK), .aclr_i(aclr_i), .async_in(async_in), .filt_bypass(filt_bypass),
        .sync_raw(raw_o[1]), .sync_out(out_o[1]), .rise(rise_o[1]), .fall(fall_o[1])
    );

    sync_filter_multi #(.WIDTH(4), .STAGES(4), .FILT_LEN(1), .INIT(4'b0000)) u_c (
        .CLK(CLK), .aclr_i(aclr_i), .async_in(async_in), .filt_bypass(filt_bypass),
        .sync_raw(raw_o[2]), .sync_out(out_o[2]), .rise(rise_o[2]), .fall(fall_o[2])
    );

    // Reference model: per build, a delay line of sampled inputs and a run length of mismatches.
    int         s_p    [ND] = '{2, 2, 4};
    int         f_p    [ND] = '{3, 3, 1};
    logic [3:0] init_p [ND] = '{4'b0000, 4'b0101, 4'b0000};

    logic [3:0] line   [ND][8];
    logic [3:0] m_out  [ND];
    logic [3:0] m_rise [ND];
    logic [3:0] m_fall [ND];
    int         run    [ND][4];

    typedef struct packed {
        logic [3:0] raw;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;
    typedef exp_t [ND-1:0] exps_t;

    exps_t sbq[$];

    int checks = 0;
    int passed = 0;

    logic [3:0] cur_a;
    logic       cur_b;
    logic       cur_r;
    logic       seen;
    int         n_rise;
    int         n_fall;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            for (int j = 0; j < 8; j++) line[d][j] = init_p[d];
            m_out[d]  = init_p[d];
            m_rise[d] = '0;
            m_fall[d] = '0;
            for (int i = 0; i < 4; i++) run[d][i] = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] a, input logic byp);
        logic [3:0] raw_b;
        logic [3:0] nout;
        for (int d = 0; d < ND; d++) begin
            raw_b = line[d][0];
            for (int j = 0; j < s_p[d] - 1; j++) line[d][j] = line[d][j+1];
            line[d][s_p[d]-1] = a;
            nout = m_out[d];
            for (int i = 0; i < 4; i++) begin
                if (byp) begin
                    nout[i] = raw_b[i];
                    run[d][i] = 0;
                end else if (raw_b[i] == m_out[d][i]) begin
                    run[d][i] = 0;
                end else begin
                    run[d][i]++;
                    if (run[d][i] == f_p[d]) begin
                        nout[i] = raw_b[i];
                        run[d][i] = 0;
                    end
                end
            end
            m_rise[d] = nout & ~m_out[d];
            m_fall[d] = ~nout & m_out[d];
            m_out[d]  = nout;
        end
    endtask

    task automatic push_exp();
        exps_t e;
        for (int d = 0; d < ND; d++) begin
            e[d].raw  = line[d][0];
            e[d].out  = m_out[d];
            e[d].rise = m_rise[d];
            e[d].fall = m_fall[d];
        end
        sbq.push_back(e);
    endtask

    // Drive one cycle's inputs on the falling edge and queue the state expected after the next rising edge.
    task automatic cycle(input logic [3:0] a, input logic byp, input logic rst);
        @(negedge CLK);
        aclr_i      = rst;
        async_in    = a;
        filt_bypass = byp;
        if (rst) model_reset();
        else     model_step(a, byp);
        push_exp();
    endtask

    task automatic cycle_obs(input logic [3:0] a, input logic byp);
        cycle(a, byp, 1'b0);
        @(posedge CLK);
        #2;
    endtask

    initial begin : monitor
        exps_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int d = 0; d < ND; d++) begin
                    chk($sformatf("sb%0d_raw", d),  raw_o[d],  e[d].raw);
                    chk($sformatf("sb%0d_out", d),  out_o[d],  e[d].out);
                    chk($sformatf("sb%0d_rise", d), rise_o[d], e[d].rise);
                    chk($sformatf("sb%0d_fall", d), fall_o[d], e[d].fall);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    initial begin : stim
        aclr_i      = 1'b1;
        async_in    = 4'b0101;
        filt_bypass = 1'b0;
        model_reset();
        #2;
        chk("rst_out_a", out_o[0], 4'b0000);
        chk("rst_out_b", out_o[1], 4'b0101);
        chk("rst_raw_b", raw_o[1], 4'b0101);
        repeat (3) cycle(4'b0101, 1'b0, 1'b1);

        // Build B preloads INIT = 0101, so matching input gives no pulses after release.
        for (int k = 0; k < 20; k++) begin
            cycle_obs(4'b0101, 1'b0);
            chk("init_out_b",  out_o[1],  4'b0101);
            chk("init_edge_b", rise_o[1] | fall_o[1], 4'b0000);
        end
        repeat (10) cycle(4'b0000, 1'b0, 1'b0);

        // Step before edge 0: A raw after edge 1, A out after edge 4; C (4 stages, no filter) after edge 4.
        for (int k = 0; k < 7; k++) begin
            cycle_obs(4'b1001, 1'b0);
            chk($sformatf("step_raw_a_e%0d", k), raw_o[0], (k >= 1) ? 4'b1001 : 4'b0000);
            chk($sformatf("step_out_a_e%0d", k), out_o[0], (k >= 4) ? 4'b1001 : 4'b0000);
            chk($sformatf("step_rise_a_e%0d", k), rise_o[0], (k == 4) ? 4'b1001 : 4'b0000);
            chk($sformatf("step_out_c_e%0d", k), out_o[2], (k >= 4) ? 4'b1001 : 4'b0000);
        end

        // Two-cycle glitch on channel 1 is rejected.
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle_obs((k < 2) ? 4'b1011 : 4'b1001, 1'b0);
            seen = seen | out_o[0][1] | rise_o[0][1] | fall_o[0][1];
        end
        chk("glitch2_ch1_a", {3'b000, seen}, 4'b0000);

        // Three-cycle pulse passes: exactly one rise and one fall.
        n_rise = 0;
        n_fall = 0;
        for (int k = 0; k < 10; k++) begin
            cycle_obs((k < 3) ? 4'b1011 : 4'b1001, 1'b0);
            n_rise += int'(rise_o[0][1]);
            n_fall += int'(fall_o[0][1]);
        end
        chk("glitch3_rise_a", 4'(n_rise), 4'd1);
        chk("glitch3_fall_a", 4'(n_fall), 4'd1);

        // Bypass: toggle channel 2 every 4 cycles.
        cur_a = 4'b1001;
        for (int k = 0; k < 20; k++) begin
            if (k % 4 == 0) cur_a[2] = ~cur_a[2];
            cycle(cur_a, 1'b1, 1'b0);
        end
        repeat (8) cycle(4'b0000, 1'b0, 1'b0);

        // All channels together, then 1111 -> 1010.
        for (int k = 0; k < 6; k++) begin
            cycle_obs(4'b1111, 1'b0);
            chk($sformatf("multi_rise_a_e%0d", k), rise_o[0], (k == 4) ? 4'b1111 : 4'b0000);
        end
        for (int k = 0; k < 6; k++) begin
            cycle_obs(4'b1010, 1'b0);
            chk($sformatf("multi_fall_a_e%0d", k), fall_o[0], (k == 4) ? 4'b0101 : 4'b0000);
            chk($sformatf("multi_rise0_a_e%0d", k), rise_o[0], 4'b0000);
        end

        // Reset mid-count on channel 0.
        repeat (8) cycle(4'b1110, 1'b0, 1'b0);
        repeat (3) cycle(4'b1111, 1'b0, 1'b0);
        @(posedge CLK);
        #3;
        aclr_i = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_out_a",  out_o[0],  4'b0000);
        chk("mid_rst_rise_a", rise_o[0], 4'b0000);
        chk("mid_rst_raw_a",  raw_o[0],  4'b0000);
        chk("mid_rst_out_b",  out_o[1],  4'b0101);
        repeat (2) cycle(4'b1111, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cycle_obs(4'b1111, 1'b0);
            chk($sformatf("post_rst_out_a_e%0d", k),  out_o[0],  (k >= 4) ? 4'b1111 : 4'b0000);
            chk($sformatf("post_rst_rise_a_e%0d", k), rise_o[0], (k == 4) ? 4'b1111 : 4'b0000);
        end

        // Random traffic with occasional bypass flips and resets.
        cur_a = 4'b1111;
        cur_b = 1'b0;
        for (int t = 0; t < 500; t++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) cur_a[i] = ~cur_a[i];
            end
            if ($urandom_range(0, 19) == 0) cur_b = ~cur_b;
            cur_r = ($urandom_range(0, 79) == 0);
            cycle(cur_a, cur_b, cur_r);
        end
        cycle(cur_a, 1'b0, 1'b0);

        repeat (3) @(posedge CLK);
        #3;
        checks++;
        if (sbq.size() == 0) passed++;
        else $display("FAIL sb_drain actual=%0d expected=0", sbq.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sync_filter_multi.md
Name: sync_filter_multi

Overview:
- Parametrised multi-channel synchroniser for asynchronous inputs (USB clock/data lines, buttons, external strobes) entering the CLK domain.
- Per channel: configurable-depth flip-flop synchroniser chain, then a consecutive-sample glitch filter, then registered rising/falling edge pulses.
- Generalises the team's fixed 2-flop 1-bit synchroniser. Adds width, depth, a reset polarity value, glitch rejection, a run-time bypass and edge detection.

Parameters:
- WIDTH, 4, number of independent channels (>=1).
- STAGES, 2, synchroniser flip-flops per channel (>=2; elaboration error if <2).
- FILT_LEN, 3, consecutive mismatching synchronised samples required before the output changes (1..256; 1 = no filtering).
- INIT, {WIDTH{1'b0}}, reset value of every sync stage and of sync_out, per channel.

Ports:
- CLK  input  1  destination-domain clock, all state on rising edge
- aclr_i  input  1  reset, asynchronous, active-high
- async_in  input  WIDTH  asynchronous inputs, no timing relation to CLK
- filt_bypass  input  1  synchronous to CLK; 1 = filter disabled
- sync_raw  output  WIDTH  last synchroniser stage, unfiltered
- sync_out  output  WIDTH  filtered, registered level
- rise  output  WIDTH  1-cycle pulse when sync_out goes 0->1
- fall  output  WIDTH  1-cycle pulse when sync_out goes 1->0

Behaviour:
- Reset (aclr_i=1, any time, asynchronous):
  - All sync stages = INIT; sync_out = INIT.
  - All counters = 0; rise = fall = 0.
  - Deassertion is not internally synchronised; aclr_i release must be synchronous to CLK upstream.
  - Because INIT preloads every stage, no edge pulse is produced after reset when async_in matches INIT.
- Sync chain per channel:
  - stage[0] <= async_in[i]; stage[n] <= stage[n-1]; sync_raw = stage[STAGES-1].
  - A level stable at edge k appears on sync_raw after edge k+STAGES-1.
  - No logic between stages; only stage[0] may go metastable.
- Filter, per channel: counter cnt, width max(1, clog2(FILT_LEN)). Each edge, if filt_bypass=0:
  - sync_raw == sync_out: cnt <= 0.
  - sync_raw != sync_out and cnt < FILT_LEN-1: cnt <= cnt+1.
  - sync_raw != sync_out and cnt == FILT_LEN-1: sync_out <= sync_raw; cnt <= 0.
  - Latency for a stable change: sync_out updates at edge k+STAGES-1+FILT_LEN. With FILT_LEN=1 this is edge k+STAGES.
  - Any sync_raw excursion lasting fewer than FILT_LEN cycles is fully rejected, and its count is discarded on the first matching sample.
- Bypass (filt_bypass=1): sync_out <= sync_raw each edge; cnt <= 0.
  - Toggling filt_bypass mid-count is legal. 1->0 restarts counting from 0. 0->1 takes sync_raw on the next edge.
- Edges:
  - rise[i] = 1 for exactly the cycle after the edge where sync_out[i] changed 0->1; fall[i] likewise for 1->0. Otherwise 0.
  - Implemented as registers, not decoded from sync_out.
  - rise and fall are never both 1 on one channel.
  - Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses.
- Reset mid-count: counter cleared, sync_out returns to INIT, and any pending pulse is dropped.

Test Plan:
- Reset (WIDTH=4, STAGES=2, FILT_LEN=3, INIT=4'b0101), async_in=4'b0101 held, release reset:
  - sync_raw and sync_out = 4'b0101; rise = fall = 0 for 20 cycles.
- Step async_in[0] 0->1 before edge 0 (defaults INIT=0, filt_bypass=0):
  - sync_raw[0] = 1 after edge 1; sync_out[0] = 1 after edge 4.
  - rise[0] = 1 only in the cycle after edge 4; other channels stay 0.
- Glitch: async_in[1] high for exactly 2 CLK cycles:
  - sync_raw[1] pulses for 2 cycles; sync_out[1] stays 0 with no rise/fall.
  - Repeat with a 3-cycle high: sync_out[1] goes 1 then back to 0, with one rise and one fall.
- Bypass: filt_bypass=1, toggle async_in[2] every 4 cycles:
  - sync_out[2] follows sync_raw[2] one cycle later, with a rise/fall on every toggle.
- Multi-channel: async_in 0000->1111 simultaneously:
  - All sync_out bits set on the same edge and all four rise bits pulse together.
  - Then 1111->1010: fall[0] and fall[2] only.
- Reset mid-filter: assert aclr_i asynchronously (mid-cycle) while cnt=1 on channel 0:
  - sync_out and rise clear immediately.
  - After release, with async_in still 1, the full STAGES-1+FILT_LEN latency is observed again.
- STAGES=4, FILT_LEN=1 build: step on async_in[3] before edge 0 -> sync_out[3] changes after edge 4.
